// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared datapath constants: word width and SLT compare FSM state encoding
package mips_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/slt_chunk_cmp.sv
// rtl/slt_chunk_cmp.sv - combinational unsigned compare of one operand chunk
//   a, b : chunk of the left / right operand
//   ne   : chunks differ
//   lt_u : a < b, unsigned
module slt_chunk_cmp #(
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic [BITS_PER_CYCLE-1:0] a,
    input  logic [BITS_PER_CYCLE-1:0] b,
    output logic                      ne,
    output logic                      lt_u
);

    assign ne   = (a != b);
    assign lt_u = (a < b);

endmodule

// File: rtl/slt_compare_seq.sv
// rtl/slt_compare_seq.sv - iterative set-less-than comparator, MSB chunk first, fixed latency
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   start             : request a compare, accepted only when idle
//   is_unsigned       : 1 = sltu/sltiu, 0 = slt/slti
//   A, B              : operands, latched on acceptance
//   busy              : compare in progress or result being presented
//   done              : one-cycle pulse, lt/S valid from this cycle
//   lt, S             : result flag and its zero-extended word for the SLT mux
module slt_compare_seq
    import mips_pkg::*;
#(
    parameter int WIDTH          = WORD_WIDTH,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic [WIDTH-1:0] S
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    CNT_TOP  = CW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             decided;
    logic             lt_r;

    logic [BITS_PER_CYCLE-1:0] chunk_a;
    logic [BITS_PER_CYCLE-1:0] chunk_b;
    logic                      chunk_ne;
    logic                      chunk_lt;
    logic                      final_lt;

    assign chunk_a = a_r[cnt*BITS_PER_CYCLE +: BITS_PER_CYCLE];
    assign chunk_b = b_r[cnt*BITS_PER_CYCLE +: BITS_PER_CYCLE];

    slt_chunk_cmp #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_chunk_cmp (
        .a   (chunk_a),
        .b   (chunk_b),
        .ne  (chunk_ne),
        .lt_u(chunk_lt)
    );

    // Result as it stands after the current chunk; used on the last CMP edge
    // so the LSB chunk can still decide the outcome.
    assign final_lt = decided ? lt_r : (chunk_ne & chunk_lt);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            decided <= 1'b0;
            lt_r    <= 1'b0;
            done    <= 1'b0;
            lt      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Flipping the sign bits maps signed order onto unsigned order.
                        a_r     <= is_unsigned ? A : (A ^ MSB_MASK);
                        b_r     <= is_unsigned ? B : (B ^ MSB_MASK);
                        cnt     <= CNT_TOP;
                        decided <= 1'b0;
                        lt_r    <= 1'b0;
                        state   <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (!decided && chunk_ne) begin
                        decided <= 1'b1;
                        lt_r    <= chunk_lt;
                    end
                    if (cnt == '0) begin
                        lt    <= final_lt;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CMP) || (state == ST_DONE);
    assign S    = {{(WIDTH-1){1'b0}}, lt};

endmodule

// File: tb/tb_slt_compare_seq.sv
// tb/tb_slt_compare_seq.sv - randomized self-checking bench for slt_compare_seq
module tb_slt_compare_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        is_unsigned = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic        lt;
    logic [31:0] S;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    slt_compare_seq #(.WIDTH(32), .BITS_PER_CYCLE(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .is_unsigned(is_unsigned),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .lt         (lt),
        .S          (S)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (u) return (a < b);
        return ($signed(a) < $signed(b));
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Presents start in the current cycle (cycle 0) and checks every cycle up to the idle one.
    task automatic do_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic u, input bit disturb);
        logic exp_lt;
        exp_lt = ref_lt(a, b, u);
        A = a; B = b; is_unsigned = u; start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (disturb && c == 2) begin
                A = 32'hFFFF_FFFF; B = 32'h0; is_unsigned = ~u;
            end
            check($sformatf("%s_busy_c%0d", tag, c), {31'b0, busy}, 32'd1);
            check($sformatf("%s_done_c%0d", tag, c), {31'b0, done}, {31'b0, (c == 5)});
            if (c < 5) next_cycle();
        end
        check({tag, "_lt"}, {31'b0, lt}, {31'b0, exp_lt});
        check({tag, "_S"}, S, {31'b0, exp_lt});
        next_cycle();
        check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_idle_done"}, {31'b0, done}, 32'd0);
        check({tag, "_hold_S"}, S, {31'b0, exp_lt});
    endtask

    initial begin
        int pulses;
        int first_pulse;
        int second_pulse;
        logic [31:0] ra, rb;

        next_cycle();
        next_cycle();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_lt", {31'b0, lt}, 32'd0);
        check("rst_S", S, 32'd0);
        reset = 1'b1;
        next_cycle();

        do_cmp("t1_signed", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_cmp("t2_unsigned", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);
        do_cmp("t2_msb", 32'h7F00_0000, 32'h80FF_FFFF, 1'b0, 1'b0);
        do_cmp("t3_equal", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
        do_cmp("t3_lsb", 32'h8000_0000, 32'h8000_0001, 1'b0, 1'b0);
        do_cmp("t3_lsb_gt", 32'h8000_0002, 32'h8000_0001, 1'b1, 1'b0);
        do_cmp("t4_stable", 32'd5, 32'd9, 1'b0, 1'b1);

        // start held for 10 cycles: one accept at cycle 0, the next in the idle cycle after done
        A = 32'd1; B = 32'd2; is_unsigned = 1'b1; start = 1'b1;
        pulses = 0; first_pulse = -1; second_pulse = -1;
        for (int c = 0; c < 14; c++) begin
            if (c == 10) start = 1'b0;
            if (c > 0 && done) begin
                pulses++;
                if (first_pulse < 0) first_pulse = c;
                else second_pulse = c;
            end
            if (c >= 6 && c <= 10) check($sformatf("t5_hold_c%0d", c), S, 32'd1);
            next_cycle();
        end
        check("t5_pulses", pulses, 32'd2);
        check("t5_first", first_pulse, 32'd5);
        check("t5_second", second_pulse, 32'd11);

        // reset during cycle 3 of a compare wipes lt (currently 1) and suppresses done
        A = 32'd3; B = 32'd3; is_unsigned = 1'b0; start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_lt", {31'b0, lt}, 32'd0);
        check("t6_S", S, 32'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) pulses++;
            next_cycle();
        end
        check("t6_no_done", pulses, 32'd0);
        do_cmp("t6_fresh", 32'hFFFF_FFF0, 32'h0000_0010, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            // bias towards long common prefixes so late chunks decide
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = {ra[31:8], rb[7:0]};
                2: rb = {ra[31:16], rb[15:0]};
                default: ;
            endcase
            do_cmp($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
